alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Issue/capture controller on the other end of the combinational ALU: accepts one decoded ALU instruction at a time and drives the ALU's op/A/B inputs.
- Captures the 64-bit result into an internal Z register, then presents a writeback to the register file (Rd) or to HI/LO (multiply).
- Sits between the instruction decode stage and the ALU/register-file datapath; replaces hard-wired T3/T4/T5 control steps.

Parameters:
- RD_W, 4, width of destination register index.
- MUL_OP, 10, opcode value whose 64-bit result goes to HI/LO.
- OP_MAX, 10, highest legal opcode; values above are illegal.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  5  ALU opcode (0 or, 1 and, 2 add, 3 sub, 4 neg, 5 shr, 6 shl, 7 ror, 8 rol, 9 shra, 10 mul).
- req_a  in  32  operand A (Ra value).
- req_b  in  32  operand B (Rb value).
- req_rd  in  RD_W  destination register index.
- alu_op  out  5  opcode to ALU.
- alu_a  out  32  ALU A input (from Y register).
- alu_b  out  32  ALU B input.
- alu_c  in  64  ALU result, combinational from alu_op/alu_a/alu_b.
- wb_valid  out  1  writeback pending.
- wb_ready  in  1  register file accepts writeback.
- wb_rd  out  RD_W  destination index; valid when wb_valid and not wb_hilo.
- wb_data  out  32  Z[31:0] (low word).
- wb_hilo  out  1  1: write HI<=hi_data and LO<=wb_data instead of Rd.
- hi_data  out  32  Z[63:32].
- illegal  out  1  one-cycle pulse on an illegal opcode.

Behaviour:
- States: IDLE, EXEC, WB.
- Reset (clr high at an edge): state IDLE. req_ready=1 next cycle. All other outputs, Y, B, Z, op and rd registers are 0.
- clr takes priority over every other event. An in-flight op is discarded with no writeback and no illegal pulse.
- req_ready = (state==IDLE) and not clr. Handshake is accepted at an edge with req_valid && req_ready.
- IDLE, accept with req_op<=OP_MAX:
  - latch Y<=req_a, B<=req_b, op<=req_op, rd<=req_rd.
  - go to EXEC.
- IDLE, accept with req_op>OP_MAX:
  - illegal=1 for exactly the next cycle.
  - stay IDLE; no writeback. A new request may be accepted in that same cycle.
- EXEC (exactly one cycle):
  - alu_op=op, alu_a=Y, alu_b=B.
  - at the end edge, Z<=alu_c (all 64 bits) and go to WB.
- Outside EXEC, alu_op, alu_a and alu_b are held at 0.
- WB:
  - wb_valid=1; wb_rd=rd; wb_data=Z[31:0]; hi_data=Z[63:32]; wb_hilo=(op==MUL_OP).
  - Outputs stay stable while wb_ready=0.
  - On an edge with wb_ready=1, go to IDLE; wb_valid drops next cycle.
- Latency: request accepted at edge k; EXEC in cycle k+1; wb_valid high from cycle k+2. Minimum issue interval is 3 cycles (back-to-back with wb_ready tied 1).
- Non-multiply ops: ALU upper 32 bits are stored in Z but not written; wb_hilo=0.
- No new request is accepted in EXEC or WB. req_valid held high there is ignored until IDLE.
- wb_ready asserted outside WB has no effect.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds outputs flag_z (1) and flag_n (1).
  - Registered at the WB->IDLE handshake edge.
  - flag_z=(Z[31:0]==0) for normal ops; flag_z=(Z==0) for MUL_OP.
  - flag_n=Z[31] for normal ops; flag_n=Z[63] for MUL_OP.
  - Flags hold until the next completed writeback; reset to 0 by clr; unchanged by illegal ops.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Add: op=2, a=5, b=7, rd=3, wb_ready=1 -> wb_valid exactly at k+2 with wb_rd=3, wb_data=12, wb_hilo=0; req_ready high again at k+3.
- Sub wrap: op=3, a=3, b=5 -> wb_data=0xFFFFFFFE; with ALU_FLAGS_EN, flag_n=1 and flag_z=0 after the handshake.
- Multiply: op=10, a=0x00010000, b=0x00010000 -> wb_hilo=1, hi_data=0x00000001, wb_data=0x00000000.
- Backpressure: op=1, a=0xF0F0F0F0, b=0xFF00FF00, wb_ready=0 for 3 cycles -> wb_valid and wb_data=0xF000F000 stable for 3 cycles, req_ready=0 throughout, then IDLE after wb_ready=1.
- Illegal: op=12 -> illegal pulses 1 cycle, wb_valid never rises, alu_op stays 0; a following op=0 with a=1, b=2 completes with wb_data=3.
- Reset mid-op: clr asserted during EXEC of op=2 -> no wb_valid, all outputs 0 the next cycle, req_ready=1 after clr deasserts.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Issue/capture controller for the combinational ALU: issues one op, captures the 64-bit result into Z, presents writeback.
// Define ALU_FLAGS_EN to add the registered flag_z/flag_n outputs.
module alu_op_sequencer #(
  parameter int RD_W   = 4,
  parameter int MUL_OP = 10,
  parameter int OP_MAX = 10
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [4:0]      req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [RD_W-1:0] req_rd,
  output logic [4:0]      alu_op,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [63:0]     alu_c,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_hilo,
  output logic [31:0]     hi_data,
  output logic            illegal
`ifdef ALU_FLAGS_EN
  ,
  output logic            flag_z,
  output logic            flag_n
`endif
);

  localparam logic [4:0] MulOp = 5'(MUL_OP);
  localparam logic [4:0] OpMax = 5'(OP_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       y_q, y_d;
  logic [31:0]       b_q, b_d;
  logic [4:0]        op_q, op_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [63:0]       z_q, z_d;
  logic              illegal_q, illegal_d;
`ifdef ALU_FLAGS_EN
  logic              flag_z_q, flag_z_d;
  logic              flag_n_q, flag_n_d;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      y_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      z_q       <= '0;
      illegal_q <= 1'b0;
`ifdef ALU_FLAGS_EN
      flag_z_q  <= 1'b0;
      flag_n_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      z_q       <= z_d;
      illegal_q <= illegal_d;
`ifdef ALU_FLAGS_EN
      flag_z_q  <= flag_z_d;
      flag_n_q  <= flag_n_d;
`endif
    end
  end

  // An illegal opcode never leaves IDLE, so the next request can be taken while the pulse is out.
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    z_d       = z_q;
    illegal_d = 1'b0;
`ifdef ALU_FLAGS_EN
    flag_z_d  = flag_z_q;
    flag_n_d  = flag_n_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_op > OpMax) begin
            illegal_d = 1'b1;
          end else begin
            y_d     = req_a;
            b_d     = req_b;
            op_d    = req_op;
            rd_d    = req_rd;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        z_d     = alu_c;
        state_d = WB;
      end
      WB: begin
        if (wb_ready) begin
          state_d = IDLE;
`ifdef ALU_FLAGS_EN
          if (op_q == MulOp) begin
            flag_z_d = (z_q == 64'd0);
            flag_n_d = z_q[63];
          end else begin
            flag_z_d = (z_q[31:0] == 32'd0);
            flag_n_d = z_q[31];
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !clr;
  assign alu_op    = (state_q == EXEC) ? op_q : '0;
  assign alu_a     = (state_q == EXEC) ? y_q  : '0;
  assign alu_b     = (state_q == EXEC) ? b_q  : '0;
  assign wb_valid  = (state_q == WB);
  assign wb_rd     = (state_q == WB) ? rd_q : '0;
  assign wb_data   = (state_q == WB) ? z_q[31:0]  : '0;
  assign hi_data   = (state_q == WB) ? z_q[63:32] : '0;
  assign wb_hilo   = (state_q == WB) && (op_q == MulOp);
  assign illegal   = illegal_q;
`ifdef ALU_FLAGS_EN
  assign flag_z    = flag_z_q;
  assign flag_n    = flag_n_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: plays the ALU itself and checks transactions against a spec-level timeline model.
// Flag checks are included when ALU_FLAGS_EN is defined.
module tb_alu_op_sequencer;

  localparam int RD_W = 4;

  logic            clk = 1'b0;
  logic            clr;
  logic            req_valid;
  logic            req_ready;
  logic [4:0]      req_op;
  logic [31:0]     req_a;
  logic [31:0]     req_b;
  logic [RD_W-1:0] req_rd;
  logic [4:0]      alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [63:0]     alu_c;
  logic            wb_valid;
  logic            wb_ready;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_hilo;
  logic [31:0]     hi_data;
  logic            illegal;
`ifdef ALU_FLAGS_EN
  logic            flag_z;
  logic            flag_n;
  logic            expFlagZ;
  logic            expFlagN;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.RD_W(RD_W), .MUL_OP(10), .OP_MAX(10)) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_hilo(wb_hilo), .hi_data(hi_data),
    .illegal(illegal)
`ifdef ALU_FLAGS_EN
    , .flag_z(flag_z), .flag_n(flag_n)
`endif
  );

  // Non-multiply ops put a distinctive upper word on the bus so capture of all 64 bits is visible on hi_data.
  function automatic logic [63:0] aluFn(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] lo;
    logic [63:0] t;
    logic [4:0]  s;
    s  = b[4:0];
    lo = 32'd0;
    t  = 64'd0;
    case (op)
      5'd0:  lo = a | b;
      5'd1:  lo = a & b;
      5'd2:  lo = a + b;
      5'd3:  lo = a - b;
      5'd4:  lo = 32'd0 - b;
      5'd5:  lo = a >> s;
      5'd6:  lo = a << s;
      5'd7:  begin t = {a, a} >> s; lo = t[31:0];  end
      5'd8:  begin t = {a, a} << s; lo = t[63:32]; end
      5'd9:  lo = $signed(a) >>> s;
      5'd10: return 64'(a) * 64'(b);
      default: lo = 32'd0;
    endcase
    return {a ^ b, lo};
  endfunction

  assign alu_c = aluFn(alu_op, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_alu_op"},   64'(alu_op),   64'd0);
    checkOutput({tag, "_alu_a"},    64'(alu_a),    64'd0);
    checkOutput({tag, "_alu_b"},    64'(alu_b),    64'd0);
    checkOutput({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    checkOutput({tag, "_wb_rd"},    64'(wb_rd),    64'd0);
    checkOutput({tag, "_wb_data"},  64'(wb_data),  64'd0);
    checkOutput({tag, "_hi_data"},  64'(hi_data),  64'd0);
    checkOutput({tag, "_wb_hilo"},  64'(wb_hilo),  64'd0);
    checkOutput({tag, "_illegal"},  64'(illegal),  64'd0);
`ifdef ALU_FLAGS_EN
    checkOutput({tag, "_flag_z"},   64'(flag_z),   64'd0);
    checkOutput({tag, "_flag_n"},   64'(flag_n),   64'd0);
`endif
  endtask

  // One legal transaction: accept, one EXEC cycle, WB held for wbDelay extra cycles, back to IDLE.
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [RD_W-1:0] rd, input int wbDelay);
    logic [63:0] z;
    logic        hilo;
    z    = aluFn(op, a, b);
    hilo = (op == 5'd10);
    checkOutput("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    wb_ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("exec_req_ready", 64'(req_ready), 64'd0);
    checkOutput("exec_wb_valid",  64'(wb_valid),  64'd0);
    checkOutput("exec_alu_op",    64'(alu_op),    64'(op));
    checkOutput("exec_alu_a",     64'(alu_a),     64'(a));
    checkOutput("exec_alu_b",     64'(alu_b),     64'(b));
    checkOutput("exec_illegal",   64'(illegal),   64'd0);
    for (int i = 0; i <= wbDelay; i++) begin
      @(negedge clk);
      checkOutput("wb_valid",     64'(wb_valid),  64'd1);
      checkOutput("wb_data",      64'(wb_data),   64'(z[31:0]));
      checkOutput("wb_hi_data",   64'(hi_data),   64'(z[63:32]));
      checkOutput("wb_hilo",      64'(wb_hilo),   64'(hilo));
      if (!hilo) checkOutput("wb_rd", 64'(wb_rd), 64'(rd));
      checkOutput("wb_req_ready", 64'(req_ready), 64'd0);
      checkOutput("wb_alu_op",    64'(alu_op),    64'd0);
      wb_ready = (i == wbDelay);
    end
    @(negedge clk);
    checkOutput("done_wb_valid",  64'(wb_valid),  64'd0);
    checkOutput("done_req_ready", 64'(req_ready), 64'd1);
`ifdef ALU_FLAGS_EN
    expFlagZ = hilo ? (z == 64'd0) : (z[31:0] == 32'd0);
    expFlagN = hilo ? z[63] : z[31];
    checkOutput("flag_z", 64'(flag_z), 64'(expFlagZ));
    checkOutput("flag_n", 64'(flag_n), 64'(expFlagN));
`endif
    req_valid = 1'b0;
    wb_ready  = 1'($urandom_range(0, 1));
  endtask

  task automatic illegalStep(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    checkOutput("ill_req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("ill_pulse",     64'(illegal),   64'd1);
    checkOutput("ill_wb_valid",  64'(wb_valid),  64'd0);
    checkOutput("ill_alu_op",    64'(alu_op),    64'd0);
    checkOutput("ill_req_ready", 64'(req_ready), 64'd1);
`ifdef ALU_FLAGS_EN
    checkOutput("ill_flag_z", 64'(flag_z), 64'(expFlagZ));
    checkOutput("ill_flag_n", 64'(flag_n), 64'(expFlagN));
`endif
  endtask

  initial begin
    clr       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_rd    = '0;
    wb_ready  = 1'b0;
`ifdef ALU_FLAGS_EN
    expFlagZ  = 1'b0;
    expFlagN  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checkOutput("reset_req_ready_in_clr", 64'(req_ready), 64'd0);
    checkAllZero("reset");
    clr = 1'b0;
    #1;
    checkOutput("reset_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);

    $display("[TB] directed: add, sub, mul, backpressure");
    applyStimulus(5'd2, 32'd5, 32'd7, 4'd3, 0);
    applyStimulus(5'd3, 32'd3, 32'd5, 4'd1, 0);
    applyStimulus(5'd10, 32'h0001_0000, 32'h0001_0000, 4'd2, 0);
    applyStimulus(5'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd5, 3);

    $display("[TB] directed: illegal opcode then or");
    illegalStep(5'd12, 32'h1234_5678, 32'h9ABC_DEF0);
    @(negedge clk);
    checkOutput("ill_pulse_width", 64'(illegal),  64'd0);
    checkOutput("ill_no_wb",       64'(wb_valid), 64'd0);
    applyStimulus(5'd0, 32'd1, 32'd2, 4'd7, 0);

    $display("[TB] directed: clear during exec");
    req_valid = 1'b1;
    req_op    = 5'd2;
    req_a     = 32'd100;
    req_b     = 32'd200;
    req_rd    = 4'd9;
    @(negedge clk);
    checkOutput("clr_exec_alu_op", 64'(alu_op), 64'd2);
    clr       = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("clr_req_ready_in_clr", 64'(req_ready), 64'd0);
`ifdef ALU_FLAGS_EN
    expFlagZ = 1'b0;
    expFlagN = 1'b0;
`endif
    checkAllZero("clr");
    clr = 1'b0;
    #1;
    checkOutput("clr_req_ready", 64'(req_ready), 64'd1);
    repeat (2) begin
      @(negedge clk);
      checkOutput("clr_no_wb", 64'(wb_valid), 64'd0);
    end

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 14));
      if (op > 5'd10) begin
        illegalStep(op, $urandom, $urandom);
      end else begin
        applyStimulus(op, $urandom, $urandom, RD_W'($urandom), int'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
